// File: rtl/rtc_write_sched.sv
// Sequences six RTC time fields through an external binary-to-BCD decoder and
// writes each result to consecutive RTC bus registers, with a per-write ack timeout.
//
// state | meaning
// IDLE  | waiting for start; err holds the last outcome
// LOAD  | present snapshot[idx] to the decoder, capture its BCD result
// REQ   | hold bus_req/bus_addr/bus_data until bus_ack or timeout
// DONE  | one-cycle done pulse after the sixth write
// ERR   | one-cycle timeout exit, err latched
module rtc_write_sched #(
   parameter logic [7:0] BASE_ADDR = 8'h21,
   parameter int         TIMEOUT   = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] seg,
   input  logic [6:0] min,
   input  logic [6:0] hora,
   input  logic [6:0] dia,
   input  logic [6:0] mes,
   input  logic [6:0] anio,
   output logic [6:0] bin_out,
   output logic       sel_hora,
   input  logic [7:0] bcd_in,
   output logic       bus_req,
   output logic [7:0] bus_addr,
   output logic [7:0] bus_data,
   input  logic       bus_ack,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {IDLE, LOAD, REQ, DONE, ERR} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [6:0] snap [6];
   logic [2:0] idx;
   logic [2:0] idx_nxt;
   logic [7:0] to_cnt;

   assign idx_nxt = idx + 3'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         idx      <= '0;
         to_cnt   <= '0;
         bin_out  <= '0;
         sel_hora <= 1'b0;
         bus_req  <= 1'b0;
         bus_addr <= '0;
         bus_data <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         for (int i = 0; i < 6; i++) snap[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  snap[0]  <= seg;
                  snap[1]  <= min;
                  snap[2]  <= hora;
                  snap[3]  <= dia;
                  snap[4]  <= mes;
                  snap[5]  <= anio;
                  idx      <= '0;
                  err      <= 1'b0;
                  busy     <= 1'b1;
                  bin_out  <= seg;
                  sel_hora <= 1'b0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               // decoder output is combinational from bin_out, valid by end of LOAD
               bus_data <= bcd_in;
               bus_addr <= BASE_ADDR + {5'd0, idx};
               bus_req  <= 1'b1;
               bin_out  <= '0;
               sel_hora <= 1'b0;
               to_cnt   <= '0;
               state    <= REQ;
            end
            REQ: begin
               if (bus_ack) begin
                  bus_req  <= 1'b0;
                  bus_addr <= '0;
                  bus_data <= '0;
                  if (idx == 3'd5) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     idx      <= idx_nxt;
                     bin_out  <= snap[idx_nxt];
                     sel_hora <= (idx_nxt == 3'd2);
                     state    <= LOAD;
                  end
               end else if (to_cnt == TO_LAST) begin
                  bus_req  <= 1'b0;
                  bus_addr <= '0;
                  bus_data <= '0;
                  err      <= 1'b1;
                  state    <= ERR;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            ERR: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_write_sched.sv
// Randomized bench for rtc_write_sched: a transaction-level timeline model predicts
// every cycle's outputs; directed bursts pin the model with literal expectations.
module tb_rtc_write_sched;

   localparam logic [7:0] BASE = 8'h21;
   localparam int         TO   = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [6:0] seg, min, hora, dia, mes, anio;
   logic [6:0] bin_out;
   logic       sel_hora;
   logic [7:0] bcd_in;
   logic       bus_req;
   logic [7:0] bus_addr, bus_data;
   logic       bus_ack;
   logic       busy, done, err;

   rtc_write_sched #(.BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start),
      .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
      .bin_out(bin_out), .sel_hora(sel_hora), .bcd_in(bcd_in),
      .bus_req(bus_req), .bus_addr(bus_addr), .bus_data(bus_data), .bus_ack(bus_ack),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] bcd(input logic [6:0] v);
      int t, o;
      t = int'(v) / 10;
      o = int'(v) % 10;
      return 8'(t * 16 + o);
   endfunction

   // external decoder
   assign bcd_in = bcd(bin_out);

   typedef struct packed {
      logic        start;
      logic        ack;
      logic [41:0] f;
      logic [27:0] exp;
   } rec_t;

   rec_t        q[$];
   logic [15:0] wlog[$];
   int          checks = 0, errors = 0;
   int          cyc = 0, start_edge = 0, done_cyc = 0, done_cnt = 0, req_cnt = 0;
   logic        m_err = 1'b0;

   always @(posedge clk) begin
      if (bus_req && bus_ack) wlog.push_back({bus_addr, bus_data});
      cyc++;
   end

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic rs();
      return ($urandom_range(0, 3) == 0);
   endfunction

   function automatic logic [41:0] rf();
      return 42'({$urandom, $urandom});
   endfunction

   function automatic rec_t mk(input logic st, input logic ak, input logic [41:0] f,
                               input logic rq, input logic [7:0] ad, input logic [7:0] dt,
                               input logic [6:0] bn, input logic sl, input logic bz,
                               input logic dn, input logic er);
      rec_t r;
      r.start = st;
      r.ack   = ak;
      r.f     = f;
      r.exp   = {rq, ad, dt, bn, sl, bz, dn, er};
      return r;
   endfunction

   function automatic logic [27:0] outs();
      return {bus_req, bus_addr, bus_data, bin_out, sel_hora, busy, done, err};
   endfunction

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++)
         q.push_back(mk(1'b0, rnd1(), rf(), 1'b0, 8'h00, 8'h00, 7'd0, 1'b0, 1'b0, 1'b0, m_err));
   endtask

   // d[k] = REQ cycle on which the k-th write is acknowledged; d[k] > TO means never
   task automatic add_burst(input logic [41:0] fp, input int d [6]);
      logic [6:0] v;
      int         n;
      q.push_back(mk(1'b1, rnd1(), fp, 1'b0, 8'h00, 8'h00, 7'd0, 1'b0, 1'b0, 1'b0, m_err));
      m_err = 1'b0;
      for (int k = 0; k < 6; k++) begin
         v = fp[7*k +: 7];
         q.push_back(mk(rs(), rnd1(), rf(), 1'b0, 8'h00, 8'h00, v, (k == 2), 1'b1, 1'b0, 1'b0));
         n = (d[k] > TO) ? TO : d[k];
         for (int j = 1; j <= n; j++)
            q.push_back(mk(rs(), (j == d[k]), rf(), 1'b1, BASE + 8'(k), bcd(v),
                           7'd0, 1'b0, 1'b1, 1'b0, 1'b0));
         if (d[k] > TO) begin
            m_err = 1'b1;
            q.push_back(mk(rs(), rnd1(), rf(), 1'b0, 8'h00, 8'h00, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1));
            return;
         end
      end
      q.push_back(mk(rs(), rnd1(), rf(), 1'b0, 8'h00, 8'h00, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0));
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, want);
      end
   endtask

   // compare outputs of the current cycle, then drive that cycle's inputs
   task automatic run_n(input int n);
      rec_t        r;
      logic [27:0] a;
      for (int i = 0; i < n && q.size() > 0; i++) begin
         r = q.pop_front();
         @(negedge clk);
         a = outs();
         checks++;
         if (a !== r.exp) begin
            errors++;
            $display("FAIL cycle_out t=%0t got req/addr/data/bin/sel/busy/done/err=%b/%h/%h/%0d/%b/%b/%b/%b expected=%b/%h/%h/%0d/%b/%b/%b/%b",
                     $time, a[27], a[26:19], a[18:11], a[10:4], a[3], a[2], a[1], a[0],
                     r.exp[27], r.exp[26:19], r.exp[18:11], r.exp[10:4], r.exp[3],
                     r.exp[2], r.exp[1], r.exp[0]);
         end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (bus_req) req_cnt++;
         if (r.start && !r.exp[2]) start_edge = cyc + 1;
         start   = r.start;
         bus_ack = r.ack;
         {anio, mes, dia, hora, min, seg} = r.f;
      end
   endtask

   task automatic run_all();
      run_n(q.size());
   endtask

   task automatic clear_stats();
      wlog.delete();
      done_cnt = 0;
      req_cnt  = 0;
   endtask

   int          d [6];
   logic [41:0] fp;
   logic [15:0] s1_exp [6];

   initial begin
      reset = 1'b0; start = 1'b0; bus_ack = 1'b0;
      {anio, mes, dia, hora, min, seg} = '0;
      @(negedge clk);
      chk("reset_state", 32'(outs()), 32'h0);
      reset = 1'b1;
      add_idle(2);
      run_all();

      // scenario 1: ack on first REQ cycle, known fields
      clear_stats();
      fp = {7'd16, 7'd4, 7'd7, 7'd12, 7'd30, 7'd45};
      d  = '{1, 1, 1, 1, 1, 1};
      add_burst(fp, d);
      add_idle(2);
      run_all();
      s1_exp = '{16'h2145, 16'h2230, 16'h2312, 16'h2407, 16'h2504, 16'h2616};
      chk("s1_nwrites", 32'(wlog.size()), 32'd6);
      for (int i = 0; i < 6 && i < wlog.size(); i++)
         chk($sformatf("s1_write%0d", i), 32'(wlog[i]), 32'(s1_exp[i]));
      chk("s1_done_latency", 32'(done_cyc - start_edge), 32'd12);
      chk("s1_done_pulses", 32'(done_cnt), 32'd1);
      chk("s1_err", 32'(err), 32'd0);

      // scenario 2: every ack on third REQ cycle
      clear_stats();
      d = '{3, 3, 3, 3, 3, 3};
      add_burst(rf(), d);
      add_idle(1);
      run_all();
      chk("s2_nwrites", 32'(wlog.size()), 32'd6);
      chk("s2_req_cycles", 32'(req_cnt), 32'd18);
      chk("s2_done_pulses", 32'(done_cnt), 32'd1);

      // scenario 3: no ack -> timeout on first write
      clear_stats();
      d = '{9, 1, 1, 1, 1, 1};
      add_burst(rf(), d);
      add_idle(2);
      run_all();
      chk("s3_req_cycles", 32'(req_cnt), 32'd4);
      chk("s3_err", 32'(err), 32'd1);
      chk("s3_busy", 32'(busy), 32'd0);
      chk("s3_no_done", 32'(done_cnt), 32'd0);

      // scenario 4: ack on the final allowed cycle wins; new start clears err
      clear_stats();
      d = '{4, 4, 1, 1, 1, 4};
      add_burst(rf(), d);
      add_idle(1);
      run_all();
      chk("s4_err", 32'(err), 32'd0);
      chk("s4_nwrites", 32'(wlog.size()), 32'd6);
      chk("s4_done_pulses", 32'(done_cnt), 32'd1);

      // scenario 6: reset during third REQ
      clear_stats();
      d = '{2, 2, 2, 2, 2, 2};
      add_burst(rf(), d);
      run_n(9);
      chk("s6_in_req", 32'(bus_req), 32'd1);
      #2 reset = 1'b0;
      start = 1'b0; bus_ack = 1'b0;
      #1 chk("s6_async_reset", 32'(outs()), 32'h0);
      q.delete();
      m_err = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      clear_stats();
      d = '{1, 1, 1, 1, 1, 1};
      add_idle(1);
      add_burst(rf(), d);
      add_idle(1);
      run_all();
      chk("s6_no_extra_done", 32'(done_cnt), 32'd1);
      if (wlog.size() > 0) chk("s6_restart_addr", 32'(wlog[0][15:8]), 32'h21);
      else chk("s6_restart_writes", 32'(wlog.size()), 32'd6);

      // randomized bursts (start noise and field changes mid-burst in every burst)
      for (int b = 0; b < 40; b++) begin
         for (int k = 0; k < 6; k++) d[k] = $urandom_range(1, TO);
         if ($urandom_range(0, 9) == 0) d[$urandom_range(0, 5)] = TO + 1;
         add_burst(rf(), d);
         add_idle($urandom_range(0, 2));
         run_all();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
